// File: rtl/regfile_writeback_arbiter.sv
// Register-file writeback arbiter: rotating-priority grant of up to WRITE_PORTS
// functional-unit writebacks per cycle onto registered regfile write ports.

module regfile_wb_port #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] data,
  output logic            we_q,
  output logic [4:0]      rd_q,
  output logic [XLEN-1:0] data_q
);
  // rd/data keep their last value on idle cycles; only we pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      we_q <= load;
      if (load) begin
        rd_q   <= rd;
        data_q <= data;
      end
    end
  end
endmodule

module regfile_writeback_arbiter #(
  parameter int NUM_UNITS    = 4,
  parameter int COMMIT_PORTS = 2,
  parameter int WRITE_PORTS  = COMMIT_PORTS,
  parameter int XLEN         = 32,
  parameter int CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_UNITS-1:0]                unit_valid,
  input  logic [NUM_UNITS-1:0][4:0]           unit_rd,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]      unit_data,
  output logic [NUM_UNITS-1:0]                unit_ack,
  input  logic                                wb_hold,
  output logic [WRITE_PORTS-1:0]              port_we,
  output logic [WRITE_PORTS-1:0][4:0]         port_rd,
  output logic [WRITE_PORTS-1:0][XLEN-1:0]    port_data,
  output logic [CNT_W-1:0]                    defer_count
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]                    rr_ptr, rr_nxt, u, skip_unit, last_unit;
  logic [WRITE_PORTS-1:0]              slot_vld;
  logic [WRITE_PORTS-1:0][4:0]         slot_rd;
  logic [WRITE_PORTS-1:0][XLEN-1:0]    slot_data;
  logic                                skip_found, any_grant, pend, conflict, placed;

  always_comb begin
    unit_ack   = '0;
    slot_vld   = '0;
    slot_rd    = '0;
    slot_data  = '0;
    skip_found = 1'b0;
    skip_unit  = '0;
    any_grant  = 1'b0;
    last_unit  = '0;
    pend       = 1'b0;
    conflict   = 1'b0;
    placed     = 1'b0;
    u          = '0;
    if (rst && !wb_hold) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        u = PTR_W'((int'(rr_ptr) + k) % NUM_UNITS);
        if (unit_valid[u]) begin
          if (unit_rd[u] == 5'd0) begin
            unit_ack[u] = 1'b1;
          end else begin
            // Two same-rd writes in one cycle would corrupt the LVT XOR banks.
            conflict = 1'b0;
            for (int s = 0; s < WRITE_PORTS; s++)
              if (slot_vld[s] && slot_rd[s] == unit_rd[u]) conflict = 1'b1;
            placed = 1'b0;
            if (conflict) begin
              pend = 1'b1;
              if (!skip_found) begin
                skip_found = 1'b1;
                skip_unit  = u;
              end
            end else begin
              for (int s = 0; s < WRITE_PORTS; s++) begin
                if (!placed && !slot_vld[s]) begin
                  slot_vld[s]  = 1'b1;
                  slot_rd[s]   = unit_rd[u];
                  slot_data[s] = unit_data[u];
                  placed       = 1'b1;
                end
              end
              if (placed) begin
                unit_ack[u] = 1'b1;
                any_grant   = 1'b1;
                last_unit   = u;
              end else begin
                pend = 1'b1;
              end
            end
          end
        end
      end
    end
    // A conflict-skipped unit gets top priority next cycle.
    rr_nxt = rr_ptr;
    if (skip_found)
      rr_nxt = skip_unit;
    else if (any_grant)
      rr_nxt = (last_unit == PTR_W'(NUM_UNITS-1)) ? '0 : last_unit + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr      <= '0;
      defer_count <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (pend && defer_count != {CNT_W{1'b1}})
        defer_count <= defer_count + CNT_W'(1);
    end
  end

  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_port
    regfile_wb_port #(.XLEN(XLEN)) u_port (
      .clk    (clk),
      .rst    (rst),
      .load   (slot_vld[p]),
      .rd     (slot_rd[p]),
      .data   (slot_data[p]),
      .we_q   (port_we[p]),
      .rd_q   (port_rd[p]),
      .data_q (port_data[p])
    );
  end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the grant rules.

module tb_regfile_writeback_arbiter;
  localparam int N  = 4;
  localparam int WP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      unit_valid;
  logic [N-1:0][4:0] unit_rd;
  logic [N-1:0][31:0] unit_data;
  logic [N-1:0]      unit_ack;
  logic              wb_hold;
  logic [WP-1:0]     port_we;
  logic [WP-1:0][4:0] port_rd;
  logic [WP-1:0][31:0] port_data;
  logic [3:0]        defer_count;

  regfile_writeback_arbiter #(
    .NUM_UNITS(N), .COMMIT_PORTS(WP), .XLEN(32), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .unit_valid(unit_valid), .unit_rd(unit_rd),
    .unit_data(unit_data), .unit_ack(unit_ack), .wb_hold(wb_hold),
    .port_we(port_we), .port_rd(port_rd), .port_data(port_data),
    .defer_count(defer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int                  m_rr = 0;
  logic [3:0]          m_defer = '0;
  logic [WP-1:0]       m_we = '0;
  logic [WP-1:0][4:0]  m_rd = '0;
  logic [WP-1:0][31:0] m_data = '0;
  int                  n_rr;
  logic [3:0]          n_defer;
  logic [WP-1:0]       n_we;
  logic [WP-1:0][4:0]  n_rd;
  logic [WP-1:0][31:0] n_data;
  logic [N-1:0]        e_ack;
  logic [N-1:0]        obs_ack;

  task automatic model_eval();
    int gu[$];
    int skip = -1;
    int last = -1;
    bit pend = 0;
    bit dup;
    e_ack = '0;
    if (rst && !wb_hold) begin
      for (int k = 0; k < N; k++) begin
        int x = (m_rr + k) % N;
        if (!unit_valid[x]) continue;
        if (unit_rd[x] == 5'd0) begin
          e_ack[x] = 1'b1;
          continue;
        end
        dup = 0;
        foreach (gu[i]) if (unit_rd[gu[i]] == unit_rd[x]) dup = 1;
        if (dup) begin
          pend = 1;
          if (skip < 0) skip = x;
        end else if (gu.size() < WP) begin
          e_ack[x] = 1'b1;
          gu.push_back(x);
          last = x;
        end else begin
          pend = 1;
        end
      end
    end
    n_we = '0;
    n_rd = m_rd;
    n_data = m_data;
    if (!rst) begin
      n_rr = 0; n_defer = '0; n_rd = '0; n_data = '0;
    end else begin
      foreach (gu[i]) begin
        n_we[i] = 1'b1;
        n_rd[i] = unit_rd[gu[i]];
        n_data[i] = unit_data[gu[i]];
      end
      n_rr = (skip >= 0) ? skip : (last >= 0) ? (last + 1) % N : m_rr;
      n_defer = (pend && m_defer != 4'hF) ? m_defer + 4'd1 : m_defer;
    end
  endtask

  // Called at the negedge after inputs are driven; returns at the next negedge.
  task automatic tick();
    #1;
    model_eval();
    obs_ack = unit_ack;
    chk("ack", unit_ack, e_ack);
    @(posedge clk);
    #1;
    m_rr = n_rr; m_defer = n_defer; m_we = n_we; m_rd = n_rd; m_data = n_data;
    chk("port_we", port_we, m_we);
    chk("port_rd", port_rd, m_rd);
    chk("port_data", port_data, m_data);
    chk("defer", defer_count, m_defer);
    @(negedge clk);
  endtask

  task automatic set_all();
    unit_valid = '1;
    for (int i = 0; i < N; i++) begin
      unit_rd[i] = 5'(i + 1);
      unit_data[i] = 32'hA000_0000 + 32'(i);
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_hold = 1'b0;
    set_all();
    repeat (3) begin
      tick();
      chk("rst_ack", obs_ack, 4'b0000);
    end
    chk("rst_we", port_we, 2'b00);
    chk("rst_defer", defer_count, 4'd0);

    // persistent rd 1..4: two grants per cycle, starting at unit 0
    rst = 1'b1;
    tick();
    chk("rr_ack0", obs_ack, 4'b0011);
    chk("rr_rd0", port_rd, {5'd2, 5'd1});
    chk("rr_defer", defer_count, 4'd1);
    tick();
    chk("rr_ack1", obs_ack, 4'b1100);

    // same-rd conflict
    rst = 1'b0; tick(); rst = 1'b1;
    unit_valid = 4'b0111;
    unit_rd[0] = 5'd5; unit_rd[1] = 5'd5; unit_rd[2] = 5'd6;
    tick();
    chk("cf_ack0", obs_ack, 4'b0101);
    chk("cf_we0", port_we, 2'b11);
    unit_valid = 4'b0010;
    tick();
    chk("cf_ack1", obs_ack, 4'b0010);
    chk("cf_port", {port_we, port_rd[0]}, {2'b01, 5'd5});

    // x0 writes consume no port
    rst = 1'b0; tick(); rst = 1'b1;
    unit_valid = 4'b0111;
    unit_rd[0] = 5'd0; unit_rd[1] = 5'd7; unit_rd[2] = 5'd8;
    tick();
    chk("x0_ack", obs_ack, 4'b0111);
    chk("x0_we", port_we, 2'b11);
    chk("x0_rd", port_rd, {5'd8, 5'd7});

    // hold blocks everything; priority resumes at unit 3
    set_all();
    wb_hold = 1'b1;
    repeat (4) begin
      tick();
      chk("hold_ack", obs_ack, 4'b0000);
      chk("hold_we", port_we, 2'b00);
      chk("hold_defer", defer_count, 4'd0);
    end
    wb_hold = 1'b0;
    tick();
    chk("hold_rr", obs_ack, 4'b1001);

    // saturation
    repeat (20) tick();
    chk("sat15", defer_count, 4'hF);
    tick();
    chk("sat_hold", defer_count, 4'hF);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!unit_valid[i] || e_ack[i]) begin
          unit_valid[i] = ($urandom_range(0, 3) != 0);
          unit_rd[i] = 5'($urandom_range(0, 7));
          unit_data[i] = $urandom;
        end
      end
      wb_hold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
